issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Dual-entry-per-cycle instruction queue between the decode stage and the launch-select stage.
- Buffers decoded instructions in program order and presents the two oldest to launch select as slot 1 (older) and slot 2 (younger), each with a receive flag.
- Consumes the 4-bit launch_flag returned by launch select and removes exactly the launched entries, including slot 2 launched alone.
- Implemented as a collapsing shift queue: entry 0 is the head.

Parameters:
- DEPTH, 8: number of entries; must be ≥ 4.
- PC_W, 32: width of pc/npc.
- DC_W, 67: width of the decodeout bundle.
- CNT_W, 4: width of count; must hold the value DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stop  in  1  pipeline stall; freezes the queue.
- flush  in  1  discard all entries (branch redirect).
- enq1_valid  in  1  decode slot 1 (older) carries an instruction.
- enq1_pc / enq1_npc  in  PC_W  slot 1 pc / next pc.
- enq1_decodeout  in  DC_W  slot 1 decoded bundle.
- enq2_valid  in  1  decode slot 2 (younger) carries an instruction.
- enq2_pc / enq2_npc  in  PC_W  slot 2 pc / next pc.
- enq2_decodeout  in  DC_W  slot 2 decoded bundle.
- enq_ready  out  1  at least 2 free entries and not stopped.
- receive_flag1  out  1  entry 0 valid.
- out1_pc / out1_npc  out  PC_W  entry 0 pc / npc.
- out1_decodeout  out  DC_W  entry 0 bundle.
- receive_flag2  out  1  entry 1 valid.
- out2_pc / out2_npc  out  PC_W  entry 1 pc / npc.
- out2_decodeout  out  DC_W  entry 1 bundle.
- launch_flag  in  4  bit [3] = inst1→exe1, [2] = inst1→exe2, [1] = inst2→exe1, [0] = inst2→exe2.
- count  out  CNT_W  number of valid entries.

Behaviour:
- Reset (rst = 0, asynchronous): all valid bits and count are 0. All out* and receive flags are 0. enq_ready is 1 once rst is released.
- Outputs are combinational from entry 0 and entry 1. When an entry is invalid, its receive flag is 0 and its pc/npc/decodeout are 0.
- Priority order: reset > flush > stop > normal operation.
- Flush: at the next edge all entries are invalid and count = 0. Same-cycle enqueues and launches are ignored.
- Stop (without flush): state holds completely, including same-cycle launches. enq_ready = 0.
- Pop decode:
  - p1 = (launch_flag[3] | launch_flag[2]) & receive_flag1.
  - p2 = (launch_flag[1] | launch_flag[0]) & receive_flag2.
  - Bits for an invalid slot are ignored.
  - Both exe bits set for one instruction counts as a single pop.
- Removal:
  - p1 & p2: entries shift down by 2.
  - p1 only: shift down by 1.
  - p2 only: entry 0 stays, entries 2..DEPTH-1 shift down by 1.
- enq_ready = ~stop & (count ≤ DEPTH-2). It is computed from the current count; no credit is taken for same-cycle pops.
- Enqueue:
  - Accepted lanes are enq1_valid & enq_ready and enq2_valid & enq_ready.
  - Accepted instructions are written at the post-removal tail: index = count − pops.
  - Slot 1 is written before slot 2.
  - If only enq2 is valid, it takes the first free index; there are no holes.
- count_next = count − pops + pushes. The queue never overflows, because enq_ready guarantees room.
- Latency: an enqueued instruction is visible on out1/out2 no earlier than the next cycle. There is no bypass from enq to out.
- Program order is preserved among remaining entries in every case.

Test Plan:
- Reset, then enqueue pc 0x100/0x104 in one cycle → next cycle count = 2, receive_flag1 = receive_flag2 = 1, out1_pc = 0x100, out2_pc = 0x104.
- Queue {0x100, 0x104, 0x108}, launch_flag = 4'b0001 → next cycle out1_pc = 0x100, out2_pc = 0x108, count = 2.
- Queue {0x100, 0x104}, launch_flag = 4'b1001 plus enqueue {0x200, 0x204} in the same cycle → next cycle out1_pc = 0x200, out2_pc = 0x204, count = 2.
- Fill to count = 7 (DEPTH = 8) → enq_ready = 0. Attempt an enqueue → count stays 7. Pop 1 → count = 6, enq_ready = 1.
- Queue of 5 entries with stop = 1, launch_flag = 4'b1000, enq valid → state unchanged, enq_ready = 0. Then flush = 1 → next cycle count = 0, receive flags = 0.
- Assert rst = 0 mid-operation with 4 entries → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_queue_if.sv
// Decode-to-launch handshake bundle for the issue queue.
// The decode/launch-select side drives through master; the queue sits on slave.
interface issue_queue_if #(
  parameter int PC_W  = 32,
  parameter int DC_W  = 67,
  parameter int CNT_W = 4
);
  logic             stop;
  logic             flush;

  logic             enq1_valid;
  logic [PC_W-1:0]  enq1_pc;
  logic [PC_W-1:0]  enq1_npc;
  logic [DC_W-1:0]  enq1_decodeout;
  logic             enq2_valid;
  logic [PC_W-1:0]  enq2_pc;
  logic [PC_W-1:0]  enq2_npc;
  logic [DC_W-1:0]  enq2_decodeout;
  logic             enq_ready;

  logic             receive_flag1;
  logic [PC_W-1:0]  out1_pc;
  logic [PC_W-1:0]  out1_npc;
  logic [DC_W-1:0]  out1_decodeout;
  logic             receive_flag2;
  logic [PC_W-1:0]  out2_pc;
  logic [PC_W-1:0]  out2_npc;
  logic [DC_W-1:0]  out2_decodeout;

  logic [3:0]       launch_flag;
  logic [CNT_W-1:0] count;

  modport master (
    output stop, flush,
    output enq1_valid, enq1_pc, enq1_npc, enq1_decodeout,
    output enq2_valid, enq2_pc, enq2_npc, enq2_decodeout,
    output launch_flag,
    input  enq_ready,
    input  receive_flag1, out1_pc, out1_npc, out1_decodeout,
    input  receive_flag2, out2_pc, out2_npc, out2_decodeout,
    input  count
  );

  modport slave (
    input  stop, flush,
    input  enq1_valid, enq1_pc, enq1_npc, enq1_decodeout,
    input  enq2_valid, enq2_pc, enq2_npc, enq2_decodeout,
    input  launch_flag,
    output enq_ready,
    output receive_flag1, out1_pc, out1_npc, out1_decodeout,
    output receive_flag2, out2_pc, out2_npc, out2_decodeout,
    output count
  );
endinterface

// File: rtl/issue_queue.sv
// Collapsing shift issue queue: two decoded instructions in per cycle,
// oldest two presented to launch select, launched entries squeezed out
// while program order of the survivors is kept. Entry 0 is the head.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int DC_W  = 67,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  issue_queue_if.slave q
);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic             valid_reg [DEPTH];
  logic [PC_W-1:0]  pc_reg    [DEPTH];
  logic [PC_W-1:0]  npc_reg   [DEPTH];
  logic [DC_W-1:0]  dc_reg    [DEPTH];
  logic [CNT_W-1:0] count_reg;

  logic             valid_next [DEPTH];
  logic [PC_W-1:0]  pc_next    [DEPTH];
  logic [PC_W-1:0]  npc_next   [DEPTH];
  logic [DC_W-1:0]  dc_next    [DEPTH];
  logic [CNT_W-1:0] count_next;

  logic             enq_ready;
  logic             pop1;
  logic             pop2;
  logic             acc1;
  logic             acc2;
  logic [CNT_W-1:0] base1;
  logic [CNT_W-1:0] base2;

  // Pop decode and post-removal tail positions; readiness ignores same-cycle pops
  always_comb begin
    enq_ready  = ~q.stop & (count_reg <= READY_MAX);
    pop1       = (q.launch_flag[3] | q.launch_flag[2]) & valid_reg[0];
    pop2       = (q.launch_flag[1] | q.launch_flag[0]) & valid_reg[1];
    acc1       = q.enq1_valid & enq_ready;
    acc2       = q.enq2_valid & enq_ready;
    base1      = count_reg - CNT_W'(pop1) - CNT_W'(pop2);
    base2      = base1 + CNT_W'(acc1);
    count_next = base2 + CNT_W'(acc2);
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam bit               HAS1    = (gi + 1 < DEPTH);
    localparam bit               HAS2    = (gi + 2 < DEPTH);
    localparam int               I1      = HAS1 ? gi + 1 : DEPTH - 1;
    localparam int               I2      = HAS2 ? gi + 2 : DEPTH - 1;
    localparam bit               IS_HEAD = (gi == 0);
    localparam logic [CNT_W-1:0] IDX     = CNT_W'(gi);

    // Per-entry next state: collapse over launched entries, then land enqueues at the tail
    always_comb begin
      valid_next[gi] = valid_reg[gi];
      pc_next[gi]    = pc_reg[gi];
      npc_next[gi]   = npc_reg[gi];
      dc_next[gi]    = dc_reg[gi];
      if (pop1 && pop2) begin
        valid_next[gi] = HAS2 && valid_reg[I2];
        pc_next[gi]    = pc_reg[I2];
        npc_next[gi]   = npc_reg[I2];
        dc_next[gi]    = dc_reg[I2];
      end else if (pop1 || (pop2 && !IS_HEAD)) begin
        // slot 2 launched alone leaves the head in place
        valid_next[gi] = HAS1 && valid_reg[I1];
        pc_next[gi]    = pc_reg[I1];
        npc_next[gi]   = npc_reg[I1];
        dc_next[gi]    = dc_reg[I1];
      end
      if (acc1 && (base1 == IDX)) begin
        valid_next[gi] = 1'b1;
        pc_next[gi]    = q.enq1_pc;
        npc_next[gi]   = q.enq1_npc;
        dc_next[gi]    = q.enq1_decodeout;
      end else if (acc2 && (base2 == IDX)) begin
        valid_next[gi] = 1'b1;
        pc_next[gi]    = q.enq2_pc;
        npc_next[gi]   = q.enq2_npc;
        dc_next[gi]    = q.enq2_decodeout;
      end
    end
  end

  // Occupancy state: flush empties the queue, stop freezes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '{default: 1'b0};
      count_reg <= '0;
    end else if (q.flush) begin
      valid_reg <= '{default: 1'b0};
      count_reg <= '0;
    end else if (!q.stop) begin
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  // Payload carries no reset; every output path is masked by its valid bit
  always_ff @(posedge clk) begin
    if (!q.stop && !q.flush) begin
      pc_reg  <= pc_next;
      npc_reg <= npc_next;
      dc_reg  <= dc_next;
    end
  end

  assign q.enq_ready      = enq_ready;
  assign q.count          = count_reg;
  assign q.receive_flag1  = valid_reg[0];
  assign q.out1_pc        = valid_reg[0] ? pc_reg[0]  : '0;
  assign q.out1_npc       = valid_reg[0] ? npc_reg[0] : '0;
  assign q.out1_decodeout = valid_reg[0] ? dc_reg[0]  : '0;
  assign q.receive_flag2  = valid_reg[1];
  assign q.out2_pc        = valid_reg[1] ? pc_reg[1]  : '0;
  assign q.out2_npc       = valid_reg[1] ? npc_reg[1] : '0;
  assign q.out2_decodeout = valid_reg[1] ? dc_reg[1]  : '0;
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus a randomized
// run compared against a queue-based model of the instruction buffer.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;
  localparam int DC_W  = 67;
  localparam int CNT_W = 4;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic [DC_W-1:0] dc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  ent_t mq[$];

  issue_queue_if #(.PC_W(PC_W), .DC_W(DC_W), .CNT_W(CNT_W)) bus ();

  issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .DC_W(DC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DC_W-1:0] mk_dc(input logic [PC_W-1:0] pc);
    return DC_W'({3'b101, pc, ~pc});
  endfunction

  function automatic logic [PC_W-1:0] m_pc(input int s);
    return (s < mq.size()) ? mq[s].pc : '0;
  endfunction

  function automatic logic [PC_W-1:0] m_npc(input int s);
    return (s < mq.size()) ? mq[s].npc : '0;
  endfunction

  function automatic logic [DC_W-1:0] m_dc(input int s);
    return (s < mq.size()) ? mq[s].dc : '0;
  endfunction

  task automatic idle();
    bus.stop = 1'b0; bus.flush = 1'b0; bus.launch_flag = 4'b0000;
    bus.enq1_valid = 1'b0; bus.enq1_pc = '0; bus.enq1_npc = '0; bus.enq1_decodeout = '0;
    bus.enq2_valid = 1'b0; bus.enq2_pc = '0; bus.enq2_npc = '0; bus.enq2_decodeout = '0;
  endtask

  task automatic set_enq(input logic v1, input logic [PC_W-1:0] pc1,
                         input logic v2, input logic [PC_W-1:0] pc2);
    bus.enq1_valid = v1; bus.enq1_pc = pc1; bus.enq1_npc = pc1 + 4; bus.enq1_decodeout = mk_dc(pc1);
    bus.enq2_valid = v2; bus.enq2_pc = pc2; bus.enq2_npc = pc2 + 4; bus.enq2_decodeout = mk_dc(pc2);
  endtask

  task automatic set_ctl(input logic stop, input logic flush, input logic [3:0] lf);
    bus.stop = stop; bus.flush = flush; bus.launch_flag = lf;
  endtask

  // Reference behaviour: a program-ordered list; launched items leave, accepted items append
  task automatic model_step();
    ent_t e;
    bit   rdy, p1, p2;
    if (bus.flush) begin
      mq.delete();
    end else if (!bus.stop) begin
      rdy = (mq.size() <= DEPTH - 2);
      p1  = (bus.launch_flag[3] || bus.launch_flag[2]) && (mq.size() >= 1);
      p2  = (bus.launch_flag[1] || bus.launch_flag[0]) && (mq.size() >= 2);
      if (p2) mq.delete(1);
      if (p1) mq.delete(0);
      if (rdy && bus.enq1_valid) begin
        e.pc = bus.enq1_pc; e.npc = bus.enq1_npc; e.dc = bus.enq1_decodeout; mq.push_back(e);
      end
      if (rdy && bus.enq2_valid) begin
        e.pc = bus.enq2_pc; e.npc = bus.enq2_npc; e.dc = bus.enq2_decodeout; mq.push_back(e);
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    $display("[%0t] %s: count=%0d rf1=%0b rf2=%0b out1_pc=%h out2_pc=%h rdy=%0b",
             $time, tag, bus.count, bus.receive_flag1, bus.receive_flag2,
             bus.out1_pc, bus.out2_pc, bus.enq_ready);
  endtask

  task automatic do_flush();
    idle(); set_ctl(1'b0, 1'b1, 4'b0000); tick("flush"); idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #3;
    n_checks++; if (bus.count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", bus.count); else n_pass++;
    n_checks++; if (bus.receive_flag1 !== 1'b0) $display("FAIL reset_rf1: got %0b expected 0", bus.receive_flag1); else n_pass++;
    n_checks++; if (bus.receive_flag2 !== 1'b0) $display("FAIL reset_rf2: got %0b expected 0", bus.receive_flag2); else n_pass++;
    n_checks++; if (bus.out1_pc !== 32'h0) $display("FAIL reset_out1_pc: got %h expected 0", bus.out1_pc); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %0b expected 1", bus.enq_ready); else n_pass++;
  endtask

  task automatic test_pair_enqueue();
    set_enq(1'b1, 32'h100, 1'b1, 32'h104);
    #1;
    n_checks++; if (bus.receive_flag1 !== 1'b0) $display("FAIL no_bypass_rf1: got %0b expected 0", bus.receive_flag1); else n_pass++;
    tick("enq 100/104");
    idle();
    n_checks++; if (bus.count !== 4'd2) $display("FAIL pair_count: got %0d expected 2", bus.count); else n_pass++;
    n_checks++; if (bus.receive_flag1 !== 1'b1 || bus.receive_flag2 !== 1'b1)
      $display("FAIL pair_flags: got %0b%0b expected 11", bus.receive_flag1, bus.receive_flag2); else n_pass++;
    n_checks++; if (bus.out1_pc !== 32'h100) $display("FAIL pair_out1_pc: got %h expected 100", bus.out1_pc); else n_pass++;
    n_checks++; if (bus.out2_pc !== 32'h104) $display("FAIL pair_out2_pc: got %h expected 104", bus.out2_pc); else n_pass++;
    n_checks++; if (bus.out1_npc !== 32'h104) $display("FAIL pair_out1_npc: got %h expected 104", bus.out1_npc); else n_pass++;
    n_checks++; if (bus.out2_decodeout !== mk_dc(32'h104))
      $display("FAIL pair_out2_dc: got %h expected %h", bus.out2_decodeout, mk_dc(32'h104)); else n_pass++;
  endtask

  task automatic test_slot2_pop();
    set_enq(1'b1, 32'h108, 1'b0, 32'h0);
    tick("enq 108");
    idle();
    set_ctl(1'b0, 1'b0, 4'b0001);
    tick("launch 0001");
    idle();
    n_checks++; if (bus.out1_pc !== 32'h100) $display("FAIL slot2_out1_pc: got %h expected 100", bus.out1_pc); else n_pass++;
    n_checks++; if (bus.out2_pc !== 32'h108) $display("FAIL slot2_out2_pc: got %h expected 108", bus.out2_pc); else n_pass++;
    n_checks++; if (bus.count !== 4'd2) $display("FAIL slot2_count: got %0d expected 2", bus.count); else n_pass++;
  endtask

  task automatic test_pop_and_enqueue();
    do_flush();
    n_checks++; if (bus.count !== 4'd0) $display("FAIL flush_count: got %0d expected 0", bus.count); else n_pass++;
    set_enq(1'b1, 32'h100, 1'b1, 32'h104);
    tick("enq 100/104");
    set_enq(1'b1, 32'h200, 1'b1, 32'h204);
    set_ctl(1'b0, 1'b0, 4'b1001);
    tick("launch 1001 + enq 200/204");
    idle();
    n_checks++; if (bus.out1_pc !== 32'h200) $display("FAIL popenq_out1_pc: got %h expected 200", bus.out1_pc); else n_pass++;
    n_checks++; if (bus.out2_pc !== 32'h204) $display("FAIL popenq_out2_pc: got %h expected 204", bus.out2_pc); else n_pass++;
    n_checks++; if (bus.count !== 4'd2) $display("FAIL popenq_count: got %0d expected 2", bus.count); else n_pass++;
  endtask

  task automatic test_invalid_slot_launch();
    do_flush();
    set_enq(1'b1, 32'h600, 1'b0, 32'h0);
    tick("enq 600");
    idle();
    set_ctl(1'b0, 1'b0, 4'b0011);
    tick("launch 0011 on empty slot 2");
    idle();
    n_checks++; if (bus.count !== 4'd1) $display("FAIL ign_slot2_count: got %0d expected 1", bus.count); else n_pass++;
    n_checks++; if (bus.out1_pc !== 32'h600) $display("FAIL ign_slot2_out1_pc: got %h expected 600", bus.out1_pc); else n_pass++;
    set_ctl(1'b0, 1'b0, 4'b1111);
    tick("launch 1111 with one entry");
    idle();
    n_checks++; if (bus.count !== 4'd0) $display("FAIL one_entry_pop_count: got %0d expected 0", bus.count); else n_pass++;
  endtask

  task automatic test_full();
    do_flush();
    for (int k = 0; k < 3; k++) begin
      set_enq(1'b1, 32'h300 + 32'(8 * k), 1'b1, 32'h304 + 32'(8 * k));
      tick("fill pair");
    end
    set_enq(1'b1, 32'h318, 1'b0, 32'h0);
    tick("fill single");
    idle();
    #1;
    n_checks++; if (bus.count !== 4'd7) $display("FAIL full_count7: got %0d expected 7", bus.count); else n_pass++;
    n_checks++; if (bus.enq_ready !== 1'b0) $display("FAIL full_ready7: got %0b expected 0", bus.enq_ready); else n_pass++;
    set_enq(1'b1, 32'h400, 1'b1, 32'h404);
    tick("enq attempt while not ready");
    idle();
    n_checks++; if (bus.count !== 4'd7) $display("FAIL full_blocked_count: got %0d expected 7", bus.count); else n_pass++;
    set_ctl(1'b0, 1'b0, 4'b1000);
    tick("launch 1000");
    idle();
    n_checks++; if (bus.count !== 4'd6) $display("FAIL full_pop_count: got %0d expected 6", bus.count); else n_pass++;
    n_checks++; if (bus.enq_ready !== 1'b1) $display("FAIL full_pop_ready: got %0b expected 1", bus.enq_ready); else n_pass++;
    n_checks++; if (bus.out1_pc !== 32'h304) $display("FAIL full_pop_out1_pc: got %h expected 304", bus.out1_pc); else n_pass++;
    set_enq(1'b1, 32'h500, 1'b1, 32'h504);
    tick("enq 500/504 to full");
    idle();
    n_checks++; if (bus.count !== 4'd8) $display("FAIL full_count8: got %0d expected 8", bus.count); else n_pass++;
    n_checks++; if (bus.enq_ready !== 1'b0) $display("FAIL full_ready8: got %0b expected 0", bus.enq_ready); else n_pass++;
    set_ctl(1'b0, 1'b0, 4'b1100);
    tick("launch 1100");
    idle();
    n_checks++; if (bus.count !== 4'd7) $display("FAIL dual_exe_single_pop: got %0d expected 7", bus.count); else n_pass++;
    n_checks++; if (bus.out1_pc !== 32'h308) $display("FAIL dual_exe_out1_pc: got %h expected 308", bus.out1_pc); else n_pass++;
  endtask

  task automatic test_stop_flush();
    do_flush();
    set_enq(1'b1, 32'h700, 1'b1, 32'h704); tick("enq 700/704");
    set_enq(1'b1, 32'h708, 1'b1, 32'h70c); tick("enq 708/70c");
    set_enq(1'b1, 32'h710, 1'b0, 32'h0);   tick("enq 710");
    set_ctl(1'b1, 1'b0, 4'b1000);
    set_enq(1'b1, 32'h800, 1'b1, 32'h804);
    #1;
    n_checks++; if (bus.enq_ready !== 1'b0) $display("FAIL stop_ready: got %0b expected 0", bus.enq_ready); else n_pass++;
    tick("stop with launch+enq");
    n_checks++; if (bus.count !== 4'd5) $display("FAIL stop_count: got %0d expected 5", bus.count); else n_pass++;
    n_checks++; if (bus.out1_pc !== 32'h700 || bus.out2_pc !== 32'h704)
      $display("FAIL stop_outs: got %h/%h expected 700/704", bus.out1_pc, bus.out2_pc); else n_pass++;
    set_ctl(1'b1, 1'b1, 4'b1000);
    tick("flush over stop");
    idle();
    n_checks++; if (bus.count !== 4'd0) $display("FAIL stopflush_count: got %0d expected 0", bus.count); else n_pass++;
    n_checks++; if (bus.receive_flag1 !== 1'b0 || bus.receive_flag2 !== 1'b0)
      $display("FAIL stopflush_flags: got %0b%0b expected 00", bus.receive_flag1, bus.receive_flag2); else n_pass++;
  endtask

  task automatic test_random();
    logic [95:0] r96;
    logic        exp_rdy;
    do_flush();
    for (int c = 0; c < 400; c++) begin
      bus.stop  = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 39) == 0);
      bus.launch_flag = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      bus.enq1_valid = ($urandom_range(0, 3) != 0);
      bus.enq1_pc = $urandom(); bus.enq1_npc = $urandom();
      r96 = {$urandom(), $urandom(), $urandom()}; bus.enq1_decodeout = r96[DC_W-1:0];
      bus.enq2_valid = ($urandom_range(0, 3) != 0);
      bus.enq2_pc = $urandom(); bus.enq2_npc = $urandom();
      r96 = {$urandom(), $urandom(), $urandom()}; bus.enq2_decodeout = r96[DC_W-1:0];
      #1;
      exp_rdy = !bus.stop && (mq.size() <= DEPTH - 2);
      n_checks++; if (bus.enq_ready !== exp_rdy)
        $display("FAIL rand_ready c=%0d: got %0b expected %0b", c, bus.enq_ready, exp_rdy); else n_pass++;
      tick("rand");
      n_checks++; if (int'(bus.count) != mq.size())
        $display("FAIL rand_count c=%0d: got %0d expected %0d", c, bus.count, mq.size()); else n_pass++;
      n_checks++; if (bus.receive_flag1 !== (mq.size() >= 1) || bus.receive_flag2 !== (mq.size() >= 2))
        $display("FAIL rand_flags c=%0d: got %0b%0b expected size %0d", c, bus.receive_flag1, bus.receive_flag2, mq.size()); else n_pass++;
      n_checks++; if (bus.out1_pc !== m_pc(0) || bus.out1_npc !== m_npc(0) || bus.out1_decodeout !== m_dc(0))
        $display("FAIL rand_slot1 c=%0d: got pc %h npc %h expected pc %h npc %h", c, bus.out1_pc, bus.out1_npc, m_pc(0), m_npc(0)); else n_pass++;
      n_checks++; if (bus.out2_pc !== m_pc(1) || bus.out2_npc !== m_npc(1) || bus.out2_decodeout !== m_dc(1))
        $display("FAIL rand_slot2 c=%0d: got pc %h npc %h expected pc %h npc %h", c, bus.out2_pc, bus.out2_npc, m_pc(1), m_npc(1)); else n_pass++;
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_flush();
    set_enq(1'b1, 32'h900, 1'b1, 32'h904); tick("enq 900/904");
    set_enq(1'b1, 32'h908, 1'b1, 32'h90c); tick("enq 908/90c");
    idle();
    n_checks++; if (bus.count !== 4'd4) $display("FAIL arst_pre_count: got %0d expected 4", bus.count); else n_pass++;
    #2;
    rst = 1'b0;
    mq.delete();
    #1;
    $display("[%0t] async reset asserted: count=%0d rf1=%0b rf2=%0b", $time, bus.count, bus.receive_flag1, bus.receive_flag2);
    n_checks++; if (bus.count !== 4'd0) $display("FAIL arst_count: got %0d expected 0", bus.count); else n_pass++;
    n_checks++; if (bus.receive_flag1 !== 1'b0 || bus.receive_flag2 !== 1'b0)
      $display("FAIL arst_flags: got %0b%0b expected 00", bus.receive_flag1, bus.receive_flag2); else n_pass++;
    n_checks++; if (bus.out1_pc !== 32'h0 || bus.out2_pc !== 32'h0)
      $display("FAIL arst_outs: got %h/%h expected 0/0", bus.out1_pc, bus.out2_pc); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_pair_enqueue();
    test_slot2_pop();
    test_pop_and_enqueue();
    test_invalid_slot_launch();
    test_full();
    test_stop_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
